// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: FSM state codes,
// opcodes (IR[15:12]), ALU operation codes, PC source selects and
// the instruction class produced by the opcode decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MULDIV = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_DIV  = 4'b0110;
    localparam logic [3:0] OP_JEQ  = 4'b0111;
    localparam logic [3:0] OP_CMP  = 4'b1000;
    localparam logic [3:0] OP_MOV  = 4'b1001;
    localparam logic [3:0] OP_J    = 4'b1010;
    localparam logic [3:0] OP_JR   = 4'b1011;
    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_LI   = 4'b1110;
    localparam logic [3:0] OP_SUB  = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_MUL   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_DIV   = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_OTHER = 3'b111;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_JMP = 2'b01;
    localparam logic [1:0] PC_REG = 2'b10;
    localparam logic [1:0] PC_JEQ = 2'b11;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MULDIV,
        CLS_JMP,
        CLS_JR,
        CLS_JEQ,
        CLS_LW,
        CLS_SW
    } op_class_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
//   master : controller side (drives control outputs, reads opcode/zero/mem_ack)
//   slave  : datapath/memory side
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       mov;
    logic       li;
    logic       cmp;
    logic       busy;
    logic [2:0] state;

    modport master (
        input  opcode, zero, mem_ack,
        output mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_src, alu_op, alu_src,
               reg_dst, reg_wr, mem_to_reg, mov, li, cmp, busy, state
    );

    modport slave (
        output opcode, zero, mem_ack,
        input  mem_rd, mem_wr, iord, ir_wr, pc_wr, pc_src, alu_op, alu_src,
               reg_dst, reg_wr, mem_to_reg, mov, li, cmp, busy, state
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode decoder.
//   i_opcode     : IR[15:12]
//   o_alu_op     : ALU operation for EXEC
//   o_alu_src    : 1 = immediate operand (ADDI, LW, SW)
//   o_reg_dst, o_mov, o_li, o_cmp, o_mem_to_reg : write-back selects
//   o_cls        : instruction class used by the FSM for sequencing
module mc_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic [2:0] o_alu_op,
    output logic       o_alu_src,
    output logic       o_reg_dst,
    output logic       o_mov,
    output logic       o_li,
    output logic       o_cmp,
    output logic       o_mem_to_reg,
    output op_class_e  o_cls
);
    always_comb begin
        o_alu_op     = ALU_OTHER;
        o_alu_src    = 1'b0;
        o_reg_dst    = 1'b0;
        o_mov        = 1'b0;
        o_li         = 1'b0;
        o_cmp        = 1'b0;
        o_mem_to_reg = 1'b0;
        o_cls        = CLS_ALU;
        case (i_opcode)
            OP_NOP:  o_cls = CLS_NOP;
            OP_ADD:  begin o_alu_op = ALU_ADD; o_reg_dst = 1'b1; end
            OP_ADDI: begin o_alu_op = ALU_ADD; o_alu_src = 1'b1; end
            OP_MUL:  begin o_alu_op = ALU_MUL; o_cls = CLS_MULDIV; end
            OP_AND:  o_alu_op = ALU_AND;
            OP_OR:   o_alu_op = ALU_OR;
            OP_DIV:  begin o_alu_op = ALU_DIV; o_cls = CLS_MULDIV; end
            OP_JEQ:  o_cls = CLS_JEQ;
            OP_CMP:  o_cmp = 1'b1;
            OP_MOV:  o_mov = 1'b1;
            OP_J:    o_cls = CLS_JMP;
            OP_JR:   o_cls = CLS_JR;
            OP_LW:   begin
                o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_mem_to_reg = 1'b1; o_cls = CLS_LW;
            end
            OP_SW:   begin o_alu_op = ALU_ADD; o_alu_src = 1'b1; o_cls = CLS_SW; end
            OP_LI:   o_li = 1'b1;
            OP_SUB:  begin o_alu_op = ALU_SUB; o_cmp = 1'b1; end
            default: ;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; forces FETCH and all outputs low
//   bus  : multicycle_ctrl_if.master (opcode/zero/mem_ack in, controls out)
// Build option: MULDIV_ITER_EN adds the MULDIV state, holding alu_op for
// MULDIV_CYCLES cycles via a 5-bit down-counter loaded in EXEC.
//
// state  | meaning
// FETCH  | read instruction at PC; load IR and PC+2 on ack
// DECODE | one idle cycle for register read
// EXEC   | ALU operation, jumps resolved here
// MULDIV | iterative MUL/DIV extension (MULDIV_ITER_EN only)
// MEM    | LW/SW data access at ALU address
// WB     | register write-back, one cycle
module multicycle_ctrl
    import cpu_pkg::*;
#(
    parameter int MULDIV_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    if (MULDIV_CYCLES < 2 || MULDIV_CYCLES > 31) begin : g_bad_cfg
        $error("MULDIV_CYCLES must be within 2..31");
    end

    state_e     r_state, w_next;
    logic [2:0] w_dec_alu_op;
    logic       w_dec_alu_src, w_dec_reg_dst, w_dec_mov, w_dec_li, w_dec_cmp, w_dec_mem_to_reg;
    op_class_e  w_dec_cls;

    logic       w_mem_rd, w_mem_wr, w_iord, w_ir_wr, w_pc_wr, w_alu_src;
    logic       w_reg_dst, w_reg_wr, w_mem_to_reg, w_mov, w_li, w_cmp;
    logic [1:0] w_pc_src;
    logic [2:0] w_alu_op;

    mc_decode u_dec (
        .i_opcode     (bus.opcode),
        .o_alu_op     (w_dec_alu_op),
        .o_alu_src    (w_dec_alu_src),
        .o_reg_dst    (w_dec_reg_dst),
        .o_mov        (w_dec_mov),
        .o_li         (w_dec_li),
        .o_cmp        (w_dec_cmp),
        .o_mem_to_reg (w_dec_mem_to_reg),
        .o_cls        (w_dec_cls)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_FETCH;
        else     r_state <= w_next;
    end

`ifdef MULDIV_ITER_EN
    logic [4:0] r_md_cnt;

    // Loaded every EXEC; only consumed when EXEC branches to MULDIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      r_md_cnt <= '0;
        else if (r_state == ST_EXEC)                  r_md_cnt <= 5'(MULDIV_CYCLES - 1);
        else if (r_state == ST_MULDIV && r_md_cnt != 5'd0) r_md_cnt <= r_md_cnt - 5'd1;
    end
`endif

    always_comb begin
        w_next       = r_state;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_iord       = 1'b0;
        w_ir_wr      = 1'b0;
        w_pc_wr      = 1'b0;
        w_pc_src     = PC_INC;
        w_alu_op     = 3'b000;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_reg_wr     = 1'b0;
        w_mem_to_reg = 1'b0;
        w_mov        = 1'b0;
        w_li         = 1'b0;
        w_cmp        = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_wr = 1'b1;
                    w_pc_wr = 1'b1;
                    w_next  = ST_DECODE;
                end
            end
            ST_DECODE: w_next = ST_EXEC;
            ST_EXEC: begin
                w_alu_op  = w_dec_alu_op;
                w_alu_src = w_dec_alu_src;
                case (w_dec_cls)
                    CLS_NOP: w_next = ST_FETCH;
                    CLS_JMP: begin w_pc_wr = 1'b1; w_pc_src = PC_JMP; w_next = ST_FETCH; end
                    CLS_JR:  begin w_pc_wr = 1'b1; w_pc_src = PC_REG; w_next = ST_FETCH; end
                    CLS_JEQ: begin w_pc_wr = bus.zero; w_pc_src = PC_JEQ; w_next = ST_FETCH; end
                    CLS_LW, CLS_SW: w_next = ST_MEM;
`ifdef MULDIV_ITER_EN
                    CLS_MULDIV: w_next = ST_MULDIV;
`endif
                    default: w_next = ST_WB;
                endcase
            end
`ifdef MULDIV_ITER_EN
            ST_MULDIV: begin
                w_alu_op = w_dec_alu_op;
                if (r_md_cnt == 5'd0) w_next = ST_WB;
            end
`endif
            ST_MEM: begin
                w_iord = 1'b1;
                if (w_dec_cls == CLS_LW) begin
                    w_mem_rd = 1'b1;
                    if (bus.mem_ack) w_next = ST_WB;
                end else if (w_dec_cls == CLS_SW) begin
                    w_mem_wr = 1'b1;
                    if (bus.mem_ack) w_next = ST_FETCH;
                end else begin
                    // IR changed under us; nothing to wait for.
                    w_next = ST_FETCH;
                end
            end
            ST_WB: begin
                w_reg_wr     = 1'b1;
                w_reg_dst    = w_dec_reg_dst;
                w_mem_to_reg = w_dec_mem_to_reg;
                w_mov        = w_dec_mov;
                w_li         = w_dec_li;
                w_cmp        = w_dec_cmp;
                w_next       = ST_FETCH;
            end
            default: w_next = ST_FETCH;
        endcase
        // FETCH would otherwise request memory while reset is held.
        if (rst) begin
            w_mem_rd = 1'b0; w_mem_wr = 1'b0; w_iord = 1'b0; w_ir_wr = 1'b0;
            w_pc_wr = 1'b0; w_pc_src = PC_INC; w_alu_op = 3'b000; w_alu_src = 1'b0;
            w_reg_dst = 1'b0; w_reg_wr = 1'b0; w_mem_to_reg = 1'b0;
            w_mov = 1'b0; w_li = 1'b0; w_cmp = 1'b0;
        end
    end

    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_wr     = w_mem_wr;
    assign bus.iord       = w_iord;
    assign bus.ir_wr      = w_ir_wr;
    assign bus.pc_wr      = w_pc_wr;
    assign bus.pc_src     = w_pc_src;
    assign bus.alu_op     = w_alu_op;
    assign bus.alu_src    = w_alu_src;
    assign bus.reg_dst    = w_reg_dst;
    assign bus.reg_wr     = w_reg_wr;
    assign bus.mem_to_reg = w_mem_to_reg;
    assign bus.mov        = w_mov;
    assign bus.li         = w_li;
    assign bus.cmp        = w_cmp;
    assign bus.busy       = (r_state != ST_FETCH) && !rst;
    assign bus.state      = r_state;
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, 16, number of EXEC-extension cycles for MUL/DIV when iterative mode is compiled in (legal range 2..31).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 opcode  in  4  IR[15:12]; sampled only in DECODE/EXEC/MEM/WB.
REQ-005 zero  in  1  ALU equality flag for JEQ; sampled in EXEC.
REQ-006 mem_ack  in  1  memory completion strobe, one cycle.
REQ-007 mem_rd, mem_wr  out  1 each  memory request; held until mem_ack.
REQ-008 iord  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-009 ir_wr, pc_wr  out  1 each  instruction-register and PC load enables.
REQ-010 pc_src  out  2  PC source: 00 = PC+2, 01 = jump target, 10 = register (JR), 11 = JEQ target.
REQ-011 alu_op  out  3  ALU operation; the encoding is the existing single-cycle decode encoding.
REQ-012 alu_src, reg_dst, reg_wr, mem_to_reg, mov, li, cmp  out  1 each  datapath selects; the meanings are unchanged from the single-cycle decode.
REQ-013 busy  out  1  high in every state except FETCH.
REQ-014 state  out  3  current FSM state, for debug.

Function
REQ-015 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MULDIV=3, MEM=4 and WB=5; codes 6-7 SHALL go to FETCH.
REQ-016 FETCH: mem_rd=1 and iord=0 until mem_ack; in the mem_ack cycle, ir_wr=1, pc_wr=1 and pc_src=00, then DECODE.
REQ-017 DECODE: 1 cycle with no enables asserted, then EXEC.
REQ-018 EXEC: drive alu_op and alu_src per the opcode table (ADD/ADDI/LW/SW=000, MUL=001, AND=010, OR=011, DIV=100, SUB=110, others=111).
REQ-019 EXEC next state: 0000 -> FETCH (NOP); 1010 -> pc_wr=1, pc_src=01, FETCH; 1011 -> pc_wr=1, pc_src=10, FETCH; 0111 -> pc_wr=zero, pc_src=11, FETCH; 1100/1101 -> MEM; all others -> WB.
REQ-020 MEM: iord=1, alu_op=000 held; LW drives mem_rd and SW drives mem_wr, each held until mem_ack; on ack, LW goes to WB and SW goes to FETCH.
REQ-021 WB: reg_wr=1 for exactly 1 cycle, then FETCH; reg_dst=1 only for ADD (0001); mem_to_reg=1 only for LW; mov/li/cmp asserted for 1001/1110/1000 respectively; cmp also asserted for SUB (1111).
REQ-022 All outputs not named for a state SHALL be 0 in that state.
REQ-023 Outputs SHALL be registered-state Moore decode, except pc_wr/ir_wr, which are combinational on mem_ack and zero.
REQ-024 A mem_ack while mem_rd=mem_wr=0 SHALL be ignored, with no state change.
REQ-025 A mem_ack in the same cycle a request is first raised SHALL complete that request; a 0-wait-state fetch takes 1 cycle.
REQ-026 Instruction latency with a 1-cycle ack: ALU op 4 cycles; LW 5; SW 4; J/JR/JEQ/NOP 3.

Reset
REQ-027 rst SHALL force state=FETCH, clear the MULDIV counter, and drive all outputs to 0 asynchronously; busy=0.
REQ-028 rst asserted mid-MEM or mid-MULDIV SHALL abort the operation immediately, dropping mem_rd/mem_wr with no write-back.
REQ-029 The first fetch SHALL begin in the first clk edge after rst deasserts.

Configuration
REQ-030 With MULDIV_ITER_EN defined, MUL (0011) and DIV (0110) SHALL go EXEC -> MULDIV, hold alu_op for MULDIV_CYCLES cycles using a 5-bit down-counter loaded in EXEC, then go to WB.
REQ-031 Without MULDIV_ITER_EN, MUL/DIV SHALL go EXEC -> WB like other ALU ops; the MULDIV state and counter SHALL be absent, and state code 3 SHALL be unreachable.

Structure
REQ-032 Shared package cpu_pkg SHALL hold the opcode constants, the alu_op constants, the pc_src encodings and the state encoding.
REQ-033 Sub-module mc_decode SHALL be the combinational opcode -> {alu_op, alu_src, reg_dst, mov, li, cmp, mem_to_reg, class} map; the FSM and counter live in multicycle_ctrl.

Verification
REQ-034 rst pulse mid-LW MEM -> mem_rd drops to 0 the same cycle; state=0 and busy=0; no reg_wr.
REQ-035 ADD (0001) with mem_ack on the first fetch cycle -> states 0,1,2,5,0; reg_wr and reg_dst are 1 only in cycle 4; alu_op=000.
REQ-036 JEQ with zero=1, then JEQ with zero=0 -> pc_wr=1 with pc_src=11 in the first case and pc_wr=0 in the second; both return to FETCH after 3 cycles.
REQ-037 SW with mem_ack delayed 3 cycles -> mem_wr=1 and iord=1 for 4 cycles, no reg_wr, then FETCH.
REQ-038 MUL with MULDIV_ITER_EN and MULDIV_CYCLES=16 -> 16 cycles with state=3 and alu_op=001, then WB; without the macro -> WB directly after EXEC.
REQ-039 Spurious mem_ack in DECODE -> no state change beyond normal sequencing; no ir_wr.
